// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port memory: data has priority, fetch wins a tie after MAX_WAIT losses.
// Two cycles minimum per access. Requests wait while BUSY. `ARB_TIMEOUT_EN adds a TIMEOUT-cycle abort with err.
module mem_port_arbiter #(
  parameter int DW       = 24,
  parameter int AW       = 24,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner,
  output logic          err
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  state_t        r_state, w_state;
  logic [3:0]    r_starve, w_starve;
  logic          r_if_gnt, w_if_gnt, r_if_done, w_if_done;
  logic          r_d_gnt, w_d_gnt, r_d_done, w_d_done;
  logic          r_mem_req, w_mem_req, r_mem_we, w_mem_we, r_owner, w_owner;
  logic [AW-1:0] r_mem_addr, w_mem_addr;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata, r_if_rdata, w_if_rdata, r_d_rdata, w_d_rdata;
  logic          w_pick_d;
`ifdef ARB_TIMEOUT_EN
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic          r_err, w_err;
`endif

  always_comb begin
    w_state     = r_state;
    w_starve    = r_starve;
    w_if_gnt    = 1'b0;
    w_d_gnt     = 1'b0;
    w_if_done   = 1'b0;
    w_d_done    = 1'b0;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_if_rdata  = r_if_rdata;
    w_d_rdata   = r_d_rdata;
    w_owner     = r_owner;
    // fetch only beats a simultaneous data request once it has lost MAX_WAIT times in a row
    w_pick_d    = d_req && !(if_req && (r_starve == LP_MAX_WAIT));
`ifdef ARB_TIMEOUT_EN
    w_err       = 1'b0;
    w_tcnt      = r_tcnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (!if_req) w_starve = '0;
        if (if_req || d_req) begin
          w_state   = S_BUSY;
          w_mem_req = 1'b1;
          w_owner   = w_pick_d;
`ifdef ARB_TIMEOUT_EN
          w_tcnt    = '0;
`endif
          if (w_pick_d) begin
            w_d_gnt     = 1'b1;
            w_mem_we    = d_we;
            w_mem_addr  = d_addr;
            w_mem_wdata = d_wdata;
            if (if_req && (r_starve != LP_MAX_WAIT)) w_starve = r_starve + 4'd1;
          end else begin
            w_if_gnt    = 1'b1;
            w_mem_we    = 1'b0;
            w_mem_addr  = if_addr;
            w_mem_wdata = '0;
            w_starve    = '0;
          end
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          w_state   = S_IDLE;
          w_mem_req = 1'b0;
          if (r_owner) begin
            w_d_done = 1'b1;
            if (!r_mem_we) w_d_rdata = mem_rdata;
          end else begin
            w_if_done  = 1'b1;
            w_if_rdata = mem_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_tcnt == LP_TO_LAST) begin
          w_state   = S_IDLE;
          w_mem_req = 1'b0;
          w_err     = 1'b1;
          if (r_owner) begin
            w_d_done  = 1'b1;
            w_d_rdata = '0;
          end else begin
            w_if_done  = 1'b1;
            w_if_rdata = '0;
          end
        end else begin
          w_tcnt = r_tcnt + TW'(1);
        end
`endif
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_starve    <= '0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_owner     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_tcnt      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_starve    <= w_starve;
      r_if_gnt    <= w_if_gnt;
      r_d_gnt     <= w_d_gnt;
      r_if_done   <= w_if_done;
      r_d_done    <= w_d_done;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_if_rdata  <= w_if_rdata;
      r_d_rdata   <= w_d_rdata;
      r_owner     <= w_owner;
`ifdef ARB_TIMEOUT_EN
      r_tcnt      <= w_tcnt;
      r_err       <= w_err;
`endif
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_done   = r_if_done;
  assign if_rdata  = r_if_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state == S_BUSY);
  assign owner     = r_owner;
`ifdef ARB_TIMEOUT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester/memory agents, a cycle model of the arbitration rules, literal pins.
module tb_mem_port_arbiter;
  localparam int DW = 24, AW = 24, MAX_WAIT = 4, TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          if_gnt, if_done, d_gnt, d_done, mem_req, mem_we, busy, owner, err;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0, cyc = 0;
  int if_left = 0, d_left = 0, lat = 1, mem_cnt = 0;
  bit stray = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return (a == 24'h000010) ? 24'hABCDEF : (a ^ 24'h5A5A5A);
  endfunction

  initial forever begin @(posedge clock); cyc++; end

  // Requesters hold req until their gnt; memory answers after lat cycles of mem_req.
  initial forever begin
    @(posedge clock);
    #1;
    if (if_gnt) if_left--;
    if_req = (if_left > 0) && !if_gnt;
    if (d_gnt) d_left--;
    d_req = (d_left > 0) && !d_gnt;
    if (mem_req) begin
      mem_ready = (mem_cnt == lat - 1);
      mem_cnt++;
    end else begin
      mem_ready = stray;
      mem_cnt = 0;
    end
    mem_rdata = mem_f(mem_addr);
  end

  // Reference model: one access in flight, described by owner/address/age.
  bit            m_busy = 0, m_owner = 0, m_we = 0, m_pick_d = 0;
  bit            m_if_gnt = 0, m_d_gnt = 0, m_if_done = 0, m_d_done = 0, m_err = 0;
  int            m_starve = 0, m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_busy = 0; m_owner = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_if_rdata = '0; m_d_rdata = '0; m_starve = 0; m_age = 0;
      m_if_gnt = 0; m_d_gnt = 0; m_if_done = 0; m_d_done = 0; m_err = 0;
    end else begin
      m_if_gnt = 0; m_d_gnt = 0; m_if_done = 0; m_d_done = 0; m_err = 0;
      if (!m_busy) begin
        if (!if_req) m_starve = 0;
        if (if_req || d_req) begin
          m_pick_d = d_req && !(if_req && m_starve == MAX_WAIT);
          m_busy = 1; m_owner = m_pick_d; m_age = 0;
          if (m_pick_d) begin
            m_d_gnt = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
            if (if_req) m_starve = (m_starve + 1 > MAX_WAIT) ? MAX_WAIT : m_starve + 1;
          end else begin
            m_if_gnt = 1; m_we = 0; m_addr = if_addr; m_wdata = '0; m_starve = 0;
          end
        end
      end else begin
        m_age++;
        if (mem_ready) begin
          m_busy = 0;
          if (m_owner) begin m_d_done = 1; if (!m_we) m_d_rdata = mem_rdata; end
          else begin m_if_done = 1; m_if_rdata = mem_rdata; end
        end else if (TO_EN && m_age >= TIMEOUT) begin
          m_busy = 0; m_err = 1;
          if (m_owner) begin m_d_done = 1; m_d_rdata = '0; end
          else begin m_if_done = 1; m_if_rdata = '0; end
        end
      end
    end
  end

  // Every-cycle comparison plus a grant log and timing capture.
  logic [31:0]   lv = '0;
  int            ln = 0, gnt_cyc = 0, done_cyc = 0;
  logic          g_we = 1'b0, done_err = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;

  initial forever begin
    @(negedge clock);
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("if_gnt", 32'(if_gnt), 32'(m_if_gnt));
    chk("d_gnt", 32'(d_gnt), 32'(m_d_gnt));
    chk("if_done", 32'(if_done), 32'(m_if_done));
    chk("d_done", 32'(d_done), 32'(m_d_done));
    chk("err", 32'(err), 32'(m_err));
    chk("if_rdata", 32'(if_rdata), 32'(m_if_rdata));
    chk("d_rdata", 32'(d_rdata), 32'(m_d_rdata));
    if (m_busy) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    if (if_gnt || d_gnt) begin
      lv = {lv[30:0], d_gnt}; ln++;
      gnt_cyc = cyc; g_addr = mem_addr; g_we = mem_we; g_wdata = mem_wdata;
    end
    if (if_done || d_done) begin done_cyc = cyc; done_err = err; end
  end

  task automatic wait_quiet(input int maxc);
    int n = 0;
    while ((if_left > 0 || d_left > 0 || busy || if_req || d_req) && n < maxc) begin
      @(posedge clock); #2; n++;
    end
    chk("quiet_within_budget", 32'(n < maxc), 32'd1);
    @(negedge clock); #1;
  endtask

  initial begin
    int n;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_mem_req", 32'(mem_req), 0);  chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);      chk("rst_err", 32'(err), 0);
    chk("rst_if_gnt", 32'(if_gnt), 0);    chk("rst_d_done", 32'(d_done), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0); chk("rst_if_rdata", 32'(if_rdata), 0);
    @(posedge clock); #3 reset_n = 1'b1;

    if_addr = 24'h000010; lat = 1; if_left = 1;
    wait_quiet(20);
    chk("fetch_addr", 32'(g_addr), 32'h10);
    chk("fetch_we", 32'(g_we), 0);
    chk("fetch_lat", 32'(done_cyc - gnt_cyc), 1);
    chk("fetch_rdata", 32'(if_rdata), 32'hABCDEF);

    d_we = 1'b1; d_addr = 24'h000100; d_wdata = 24'h123456; d_left = 1;
    wait_quiet(20);
    chk("store_we", 32'(g_we), 1);
    chk("store_wdata", 32'(g_wdata), 32'h123456);
    chk("store_keeps_rdata", 32'(d_rdata), 0);

    stray = 1'b1; repeat (3) @(posedge clock); stray = 1'b0;
    d_we = 1'b0; d_addr = 24'h000200; lat = 3; d_left = 1;
    wait_quiet(20);
    chk("load_lat", 32'(done_cyc - gnt_cyc), 3);
    chk("load_rdata", 32'(d_rdata), 32'h5A585A);
    chk("load_keeps_if_rdata", 32'(if_rdata), 32'hABCDEF);
    d_we = 1'b1; d_wdata = 24'h777777; lat = 1; d_left = 1;
    wait_quiet(20);
    chk("store2_keeps_rdata", 32'(d_rdata), 32'h5A585A);

    d_we = 1'b0; lv = '0; ln = 0; if_left = 1; d_left = 1;
    wait_quiet(30);
    chk("simul_count", 32'(ln), 2);
    chk("simul_order", lv, 32'b10);

    lv = '0; ln = 0; if_left = 2; d_left = 5;
    wait_quiet(100);
    chk("starve_count", 32'(ln), 7);
    chk("starve_order", lv, 32'b1111010);

    if_addr = 24'h000040; lat = 1000; if_left = 1; n = 0;
    while (!busy && n < 20) begin @(posedge clock); #2; n++; end
    chk("busy_before_reset", 32'(busy), 1);
    @(posedge clock); #3 reset_n = 1'b0; #1;
    chk("arst_mem_req", 32'(mem_req), 0);  chk("arst_busy", 32'(busy), 0);
    chk("arst_if_done", 32'(if_done), 0);  chk("arst_if_gnt", 32'(if_gnt), 0);
    chk("arst_if_rdata", 32'(if_rdata), 0);
    lat = 1; repeat (2) @(posedge clock); #3 reset_n = 1'b1;
    lv = '0; ln = 0; if_left = 1;
    wait_quiet(20);
    chk("post_rst_count", 32'(ln), 1);
    chk("post_rst_owner", lv, 0);
    chk("post_rst_rdata", 32'(if_rdata), 32'h5A5A1A);

`ifdef ARB_TIMEOUT_EN
    d_we = 1'b0; d_addr = 24'h000200; lat = 1; d_left = 1;
    wait_quiet(20);
    d_addr = 24'h000300; lat = 1000; d_left = 1;
    wait_quiet(40);
    chk("to_lat", 32'(done_cyc - gnt_cyc), 16);
    chk("to_err", 32'(done_err), 1);
    chk("to_rdata", 32'(d_rdata), 0);
    lat = 16; d_left = 1;
    wait_quiet(40);
    chk("to_edge_lat", 32'(done_cyc - gnt_cyc), 16);
    chk("to_edge_err", 32'(done_err), 0);
    chk("to_edge_rdata", 32'(d_rdata), 32'h5A595A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
